// File: rtl/lsu_subword_rmw.sv
// lsu_subword_rmw: load/store sequencer between EX/MEM and a word-wide data memory.
// Loads are word-aligned reads with lane extraction and sign/zero extension. Sub-word
// stores (SB/SH) become read-modify-write so that neighbouring bytes survive the
// memory's whole-word write. Misaligned or unsupported requests are rejected with a
// one-cycle misalign pulse and never touch memory. Every output is registered.
// DATA_W is a parameter for readability only; the lane logic assumes 32 bits.
module lsu_subword_rmw #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  req_ready,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  ld_valid,
  output logic                  misalign,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    RMW_WAIT,
    RMW_WR,
    WR
  } state_t;

  // RV32I funct3 encodings used by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            lane_q, lane_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  req_ready_d;
  logic [DATA_W-1:0]     ld_data_d;
  logic                  ld_valid_d;
  logic                  misalign_d;
  logic [DM_ADDRESS-1:0] mem_addr_d;
  logic                  mem_we_d;
  logic [DATA_W-1:0]     mem_wdata_d;

  // A request is rejected when its width does not fit its byte offset, or when the
  // funct3 has no meaning for that direction (stores only define B/H/W).
  function automatic logic is_rejected(input logic       write,
                                       input logic [2:0] f3,
                                       input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:  bad = 1'b0;
      F3_H:  bad = lane[0];
      F3_W:  bad = (lane != 2'b00);
      F3_BU: bad = write;
      F3_HU: bad = write | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed byte/half out of the returned word and extend it to 32 bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0]        f3,
                                                    input logic [1:0]        lane,
                                                    input logic [DATA_W-1:0] word);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{(DATA_W-8){b[7]}}, b};
      F3_H:    r = {{(DATA_W-16){h[15]}}, h};
      F3_BU:   r = {{(DATA_W-8){1'b0}}, b};
      F3_HU:   r = {{(DATA_W-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the store data onto the word read back from memory, leaving other lanes intact.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [2:0]        f3,
                                                   input logic [1:0]        lane,
                                                   input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] r;
    r = old_word;
    if (f3 == F3_H) r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else            r[{lane, 3'b000} +: 8]      = wdata[7:0];
    return r;
  endfunction

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned
    // (which would infer a latch); pulses default low, held data defaults to its register.
    state_d     = state_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    ld_data_d   = ld_data;
    ld_valid_d  = 1'b0;
    misalign_d  = 1'b0;
    mem_addr_d  = mem_addr;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d       = req_funct3;
          lane_d     = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[DM_ADDRESS-1:2], 2'b00};
          if (is_rejected(req_write, req_funct3, req_addr[1:0])) begin
            misalign_d = 1'b1;
          end else if (!req_write) begin
            state_d = RD_WAIT;
          end else if (req_funct3 == F3_W) begin
            // Full-word store needs no read: write straight away.
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = RMW_WAIT;
          end
        end
      end
      RD_WAIT: state_d = RD_DONE;
      RD_DONE: begin
        ld_data_d  = load_extend(f3_q, lane_q, mem_rdata);
        ld_valid_d = 1'b1;
        state_d    = IDLE;
      end
      RMW_WAIT: begin
        // mem_rdata already reflects mem_addr here; merge and raise the write strobe.
        mem_wdata_d = lane_merge(f3_q, lane_q, mem_rdata, wdata_q);
        mem_we_d    = 1'b1;
        state_d     = RMW_WR;
      end
      RMW_WR:  state_d = IDLE;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any sequence and drops the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the captured request fields are reset too, not just the FSM, so no output
      // can ever present an X after reset even though their values are don't-care in IDLE.
      state_q   <= IDLE;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      ld_data   <= '0;
      ld_valid  <= 1'b0;
      misalign  <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      req_ready <= req_ready_d;
      ld_data   <= ld_data_d;
      ld_valid  <= ld_valid_d;
      misalign  <= misalign_d;
      mem_addr  <= mem_addr_d;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// tb_lsu_subword_rmw: transaction-level model of the load/store sequencer. Each accepted
// request is turned into a schedule of expected output events keyed by clock cycle, and a
// single negedge process compares the DUT outputs against that schedule every cycle.
module tb_lsu_subword_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misalign;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_subword_rmw #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .misalign   (misalign),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: read word follows mem_addr, whole-word write on the clock edge.
  logic [31:0] mem [128];
  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;

  // Counters and bookkeeping
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  always @(posedge clk) cyc++;

  // Reference model state: memory image and expected events keyed by cycle number
  logic [31:0] mm [128];
  bit          exp_busy [int];
  bit          exp_mis  [int];
  logic [31:0] exp_ld   [int];
  logic [31:0] exp_wd   [int];
  int          exp_wi   [int];

  // Observed values used by the hand-computed checks
  logic [31:0] last_ld;
  logic [31:0] last_wd;
  logic [8:0]  last_wa;
  int          we_count  = 0;
  int          mis_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, got, exp);
    end
  endtask

  // Which requests the sequencer must refuse, straight from the ISA rules.
  function automatic bit model_bad(input bit w, input logic [2:0] f3, input logic [1:0] off);
    if (w) begin
      if (f3 == 3'd0) return 1'b0;
      if (f3 == 3'd1) return off[0];
      if (f3 == 3'd2) return off != 2'd0;
      return 1'b1;
    end
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return off[0];
    if (f3 == 3'd2) return off != 2'd0;
    return 1'b1;
  endfunction

  // Load result by shifting the word down and masking/extending arithmetically.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * off);
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFF_FF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  // Record what an accept at posedge number k must produce.
  task automatic model_accept(input int k, input bit w, input logic [2:0] f3,
                              input logic [8:0] a, input logic [31:0] d);
    int          wi;
    logic [31:0] mask;
    wi = int'(a[8:2]);
    if (model_bad(w, f3, a[1:0])) begin
      exp_mis[k] = 1'b1;
    end else if (!w) begin
      exp_busy[k] = 1'b1; exp_busy[k+1] = 1'b1;
      exp_ld[k+2] = model_load(f3, a[1:0], mm[wi]);
    end else if (f3 == 3'd2) begin
      exp_busy[k] = 1'b1;
      exp_wd[k] = d; exp_wi[k] = wi;
    end else begin
      mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * a[1:0]);
      exp_busy[k] = 1'b1; exp_busy[k+1] = 1'b1;
      exp_wd[k+1] = (mm[wi] & ~mask) | ((d << (8 * a[1:0])) & mask);
      exp_wi[k+1] = wi;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the scheduled events.
  always @(negedge clk) begin
    if (chk_en) begin
      if (reset) begin
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_ld_valid", ld_valid, 0);
        check("rst_misalign", misalign, 0);
        check("rst_ld_data", ld_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
      end else begin
        check("req_ready", req_ready, exp_busy.exists(cyc) ? 0 : 1);
        check("mem_we", mem_we, exp_wd.exists(cyc) ? 1 : 0);
        if (exp_wd.exists(cyc)) begin
          check("mem_addr", mem_addr, {exp_wi[cyc][6:0], 2'b00});
          check("mem_wdata", mem_wdata, exp_wd[cyc]);
          mm[exp_wi[cyc]] = exp_wd[cyc];
        end
        check("ld_valid", ld_valid, exp_ld.exists(cyc) ? 1 : 0);
        if (exp_ld.exists(cyc)) check("ld_data", ld_data, exp_ld[cyc]);
        check("misalign", misalign, exp_mis.exists(cyc) ? 1 : 0);
      end
      if (mem_we)   begin we_count++; last_wa = mem_addr; last_wd = mem_wdata; end
      if (ld_valid) last_ld = ld_data;
      if (misalign) mis_count++;
    end
  end

  // Present a request at a negedge and keep it until accepted; return just after the
  // accepting edge. With hold=0 req_valid drops right after that edge.
  task automatic issue(input bit w, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] d, input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready still 0 after %0d cycles, expected 1", waited);
      req_valid = 1'b0;
      return;
    end
    model_accept(cyc + 1, w, f3, a, d);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic expect_ld(input string name, input logic [31:0] exp);
    repeat (3) @(negedge clk);
    #1;
    check(name, last_ld, exp);
  endtask

  initial begin
    int          we0;
    int          mis0;
    bit          w;
    logic [2:0]  f3;
    logic [8:0]  a;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[1]  = 32'h1234_80FF;
    mem[2]  = 32'hBEEF_0000;
    mem[4]  = 32'h1122_3344;
    mem[5]  = 32'h5566_7788;
    mem[8]  = 32'h0000_0000;
    mem[12] = 32'hCAFE_F00D;
    for (int i = 0; i < 128; i++) mm[i] = mem[i];
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // LB sign-extends the 0x80 byte at offset 1
    issue(1'b0, 3'd0, 9'h005, 32'h0, 1'b0);
    expect_ld("lb_0x005", 32'hFFFF_FF80);
    // LHU / LH of the upper half
    issue(1'b0, 3'd5, 9'h00A, 32'h0, 1'b0);
    expect_ld("lhu_0x00A", 32'h0000_BEEF);
    issue(1'b0, 3'd1, 9'h00A, 32'h0, 1'b0);
    expect_ld("lh_0x00A", 32'hFFFF_BEEF);

    // SB into the top byte: exactly one write of the merged word
    we0 = we_count;
    issue(1'b1, 3'd0, 9'h013, 32'h0000_00AA, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("sb_waddr", last_wa, 9'h010);
    check("sb_wdata", last_wd, 32'hAA22_3344);
    @(negedge clk);
    #1;
    check("sb_we_pulses", we_count - we0, 1);

    // SW writes once; misaligned SH is refused without a write
    issue(1'b1, 3'd2, 9'h020, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    #1;
    check("sw_wdata", last_wd, 32'hDEAD_BEEF);
    we0 = we_count; mis0 = mis_count;
    issue(1'b1, 3'd1, 9'h021, 32'h0000_1234, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("sh_mis_pulses", mis_count - mis0, 1);
    check("sh_no_write", we_count - we0, 0);

    // Reset during RMW_WAIT of an SB: no write, word unchanged, ready after reset
    we0 = we_count;
    issue(1'b1, 3'd0, 9'h016, 32'h0000_0077, 1'b0);
    reset = 1'b1;
    exp_busy.delete(); exp_mis.delete(); exp_ld.delete(); exp_wd.delete(); exp_wi.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_abort_word", mem[5], 32'h5566_7788);
    check("rst_abort_no_we", we_count - we0, 0);
    check("rst_abort_ready", req_ready, 1);

    // SB with req_valid held, then LW of the same word returns the merged value
    issue(1'b1, 3'd0, 9'h031, 32'h0000_005A, 1'b1);
    issue(1'b0, 3'd2, 9'h030, 32'h0, 1'b0);
    expect_ld("lw_after_sb", 32'hCAFE_5A0D);

    // Randomized traffic, occasionally with idle gaps between requests
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (w && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 ^ 3'b100;
      a  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      issue(w, f3, a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    for (int i = 0; i < 128; i++) check("mem_final", mem[i], mm[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
